// File: rtl/cpu_types_pkg.sv
// Shared types for the memory stage: 32-bit word type, MEM-stage FSM states and a
// helper that extracts the word index used for link-address comparisons.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    function automatic logic [29:0] word_idx(input word_t addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_link_reg.sv
// LL/SC link register: tracks one linked word, cleared by matching stores, matching
// snoop invalidates and by any completed SC; reports whether an SC may succeed.
module link_reg
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        set_link,
    input  logic [29:0] set_idx,
    input  logic        store_done,
    input  logic [29:0] store_idx,
    input  logic        sc_done,
    input  logic        snoop_inv,
    input  logic [29:0] snoop_idx,
    input  logic [29:0] sc_idx,
    output logic        sc_ok
);

    logic        link_valid_reg;
    logic [29:0] link_addr_reg;
    logic        snoop_hit;
    logic        store_hit;

    assign snoop_hit = snoop_inv && (snoop_idx == link_addr_reg);
    assign store_hit = store_done && (store_idx == link_addr_reg);
    // A snoop arriving in the same cycle as the SC check already kills the link.
    assign sc_ok     = link_valid_reg && (sc_idx == link_addr_reg) && !snoop_hit;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            link_valid_reg <= 1'b0;
            link_addr_reg  <= '0;
        end else if (set_link) begin
            // A fresh link survives unless the same word is invalidated this cycle.
            link_valid_reg <= !(snoop_inv && (snoop_idx == set_idx));
            link_addr_reg  <= set_idx;
        end else if (snoop_hit || store_hit || sc_done) begin
            link_valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one dcache request per EX/MEM memory op and stalls
// the pipeline until dhit. LL/SC link tracking is built only with MEM_STAGE_LLSC_EN.
module mem_stage_ctrl
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  valid_EX_MEM,
    input  logic  dREN_EX_MEM,
    input  logic  dWEN_EX_MEM,
    input  logic  ll_EX_MEM,
    input  logic  sc_EX_MEM,
    input  word_t result_EX_MEM,
    input  word_t dmemstore_EX_MEM,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output word_t dmemload_MEM,
    output logic  enable_EX_MEM,
    output logic  enable_MEM_WB,
    output logic  stall_MEM
);

    mem_state_t state_reg;
    logic       is_load_reg;
    logic       is_store_reg;
    logic       is_sc_reg;
    logic       mem_op;
    logic       is_store_in;
    logic       is_sc_in;
    logic       sc_fail;
    logic       req_done;
    logic       unused_bits;

    assign mem_op      = valid_EX_MEM && (dREN_EX_MEM || dWEN_EX_MEM);
    assign is_store_in = dWEN_EX_MEM && !dREN_EX_MEM;
    assign is_sc_in    = is_store_in && sc_EX_MEM;
    assign req_done    = (state_reg == REQ) && dhit;

`ifdef MEM_STAGE_LLSC_EN
    logic is_ll_reg;
    logic sc_ok;

    link_reg u_link_reg (
        .CLK        (CLK),
        .nRST       (nRST),
        .set_link   (req_done && is_ll_reg),
        .set_idx    (word_idx(dmemaddr)),
        .store_done (req_done && is_store_reg),
        .store_idx  (word_idx(dmemaddr)),
        .sc_done    ((state_reg == DONE) && is_sc_reg),
        .snoop_inv  (snoop_inv),
        .snoop_idx  (word_idx(snoop_addr)),
        .sc_idx     (word_idx(result_EX_MEM)),
        .sc_ok      (sc_ok)
    );

    assign sc_fail     = is_sc_in && !sc_ok;
    assign unused_bits = ^{result_EX_MEM[1:0], snoop_addr[1:0]};
`else
    assign sc_fail     = 1'b0;
    assign unused_bits = ^{result_EX_MEM[1:0], snoop_inv, snoop_addr, ll_EX_MEM};
`endif

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_reg    <= IDLE;
            dmemREN      <= 1'b0;
            dmemWEN      <= 1'b0;
            dmemaddr     <= '0;
            dmemstore    <= '0;
            dmemload_MEM <= '0;
            is_load_reg  <= 1'b0;
            is_store_reg <= 1'b0;
            is_sc_reg    <= 1'b0;
`ifdef MEM_STAGE_LLSC_EN
            is_ll_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        dmemaddr     <= {result_EX_MEM[31:2], 2'b00};
                        dmemstore    <= dmemstore_EX_MEM;
                        is_load_reg  <= dREN_EX_MEM;
                        is_store_reg <= is_store_in;
                        is_sc_reg    <= is_sc_in;
`ifdef MEM_STAGE_LLSC_EN
                        is_ll_reg    <= dREN_EX_MEM && ll_EX_MEM;
`endif
                        if (sc_fail) begin
                            dmemload_MEM <= '0;
                            state_reg    <= DONE;
                        end else begin
                            dmemREN   <= dREN_EX_MEM;
                            dmemWEN   <= is_store_in;
                            state_reg <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dhit) begin
                        dmemREN   <= 1'b0;
                        dmemWEN   <= 1'b0;
                        state_reg <= DONE;
                        if (is_load_reg) begin
                            dmemload_MEM <= dmemload;
                        end else if (is_sc_reg) begin
                            dmemload_MEM <= 32'd1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Enables are combinational so a non-memory op flows through with no added latency.
    assign enable_EX_MEM = (state_reg == DONE) || ((state_reg == IDLE) && !mem_op);
    assign enable_MEM_WB = enable_EX_MEM;
    assign stall_MEM     = !enable_EX_MEM;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed table, reset-in-REQ sequence and
// randomized ops against a transaction-level model (LL/SC checks follow MEM_STAGE_LLSC_EN).
module tb_mem_stage_ctrl;

`ifdef MEM_STAGE_LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    logic        CLK;
    logic        nRST;
    logic        valid_EX_MEM, dREN_EX_MEM, dWEN_EX_MEM, ll_EX_MEM, sc_EX_MEM;
    logic [31:0] result_EX_MEM, dmemstore_EX_MEM;
    logic        dhit;
    logic [31:0] dmemload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore, dmemload_MEM;
    logic        enable_EX_MEM, enable_MEM_WB, stall_MEM;

    mem_stage_ctrl dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .valid_EX_MEM     (valid_EX_MEM),
        .dREN_EX_MEM      (dREN_EX_MEM),
        .dWEN_EX_MEM      (dWEN_EX_MEM),
        .ll_EX_MEM        (ll_EX_MEM),
        .sc_EX_MEM        (sc_EX_MEM),
        .result_EX_MEM    (result_EX_MEM),
        .dmemstore_EX_MEM (dmemstore_EX_MEM),
        .dhit             (dhit),
        .dmemload         (dmemload),
        .snoop_inv        (snoop_inv),
        .snoop_addr       (snoop_addr),
        .dmemREN          (dmemREN),
        .dmemWEN          (dmemWEN),
        .dmemaddr         (dmemaddr),
        .dmemstore        (dmemstore),
        .dmemload_MEM     (dmemload_MEM),
        .enable_EX_MEM    (enable_EX_MEM),
        .enable_MEM_WB    (enable_MEM_WB),
        .stall_MEM        (stall_MEM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        v, r, w, ll, sc;
        logic [31:0] addr, data;
        int          misses;
        logic [31:0] ld;
        logic        snp;
        logic [31:0] saddr;
        int          exp_stalls;
        logic [31:0] exp_ld;
    } op_t;

    int          checks = 0;
    int          failures = 0;
    int          op_num = 0;
    // Reference state: current MEM/WB load value and the link register.
    logic [31:0] exp_ld_m = 32'h0;
    bit          link_v = 1'b0;
    logic [29:0] link_a = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s op=%0d actual=%h required=%h", name, op_num, act, exp);
        end
    endtask

    function automatic op_t mk(input logic v, r, w, ll, sc, input logic [31:0] a, d,
                               input int m, input logic [31:0] ld, input logic snp,
                               input logic [31:0] sa, input int es, input logic [31:0] el);
        op_t o;
        o.v = v; o.r = r; o.w = w; o.ll = ll; o.sc = sc; o.addr = a; o.data = d;
        o.misses = m; o.ld = ld; o.snp = snp; o.saddr = sa; o.exp_stalls = es; o.exp_ld = el;
        return o;
    endfunction

    // Runs one EX/MEM instruction from its first IDLE cycle until the pipeline advances.
    // Entered and left 1 time unit after a rising edge.
    task automatic run_op(input op_t op, output int stalls, output logic [31:0] ld_out);
        bit mem, ld_op, sc_op, fail;
        int n_req, exp_st;
        mem   = op.v && (op.r || op.w);
        ld_op = op.r;
        sc_op = op.w && !op.r && op.sc;
        valid_EX_MEM = op.v; dREN_EX_MEM = op.r; dWEN_EX_MEM = op.w;
        ll_EX_MEM = op.ll; sc_EX_MEM = op.sc;
        result_EX_MEM = op.addr; dmemstore_EX_MEM = op.data;
        snoop_inv = op.snp; snoop_addr = op.saddr;
        dhit = 1'($urandom_range(0, 1)); dmemload = $urandom;
        if (LLSC && op.snp && link_v && op.saddr[31:2] == link_a) link_v = 1'b0;
        fail   = LLSC && mem && sc_op && !(link_v && link_a == op.addr[31:2]);
        n_req  = (!mem || fail) ? 0 : op.misses + 1;
        exp_st = !mem ? 0 : (fail ? 1 : op.misses + 2);
        stalls = 0;
        ld_out = exp_ld_m;

        @(negedge CLK);
        stalls += int'(stall_MEM);
        chk("idle_stall", 32'(stall_MEM), 32'(mem));
        chk("idle_en_ex", 32'(enable_EX_MEM), 32'(!mem));
        chk("idle_en_wb", 32'(enable_MEM_WB), 32'(!mem));
        chk("idle_req", {30'd0, dmemREN, dmemWEN}, 32'd0);
        chk("idle_ld", dmemload_MEM, exp_ld_m);
        @(posedge CLK); #1;
        snoop_inv = 1'b0;

        if (mem) begin
            for (int k = 0; k < n_req; k++) begin
                dhit = (k == n_req - 1);
                dmemload = dhit ? op.ld : $urandom;
                @(negedge CLK);
                stalls += int'(stall_MEM);
                chk("req_ren", 32'(dmemREN), 32'(ld_op));
                chk("req_wen", 32'(dmemWEN), 32'(!ld_op));
                chk("req_addr", dmemaddr, {op.addr[31:2], 2'b00});
                chk("req_store", dmemstore, op.data);
                chk("req_en", 32'(enable_MEM_WB), 32'd0);
                @(posedge CLK); #1;
            end
            if (fail) exp_ld_m = 32'h0;
            else if (ld_op) exp_ld_m = op.ld;
            else if (sc_op) exp_ld_m = 32'h1;
            if (LLSC) begin
                if (!fail && ld_op && op.ll) begin
                    link_v = 1'b1;
                    link_a = op.addr[31:2];
                end
                if (!fail && !ld_op && link_a == op.addr[31:2]) link_v = 1'b0;
                if (sc_op) link_v = 1'b0;
            end
            dhit = 1'($urandom_range(0, 1)); dmemload = $urandom;
            @(negedge CLK);
            stalls += int'(stall_MEM);
            chk("done_en_ex", 32'(enable_EX_MEM), 32'd1);
            chk("done_en_wb", 32'(enable_MEM_WB), 32'd1);
            chk("done_req", {30'd0, dmemREN, dmemWEN}, 32'd0);
            chk("done_ld", dmemload_MEM, exp_ld_m);
            ld_out = dmemload_MEM;
            @(posedge CLK); #1;
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_st));
        $display("op %0d v=%0b r=%0b w=%0b ll=%0b sc=%0b addr=%h stalls=%0d ld_MEM=%h",
                 op_num, op.v, op.r, op.w, op.ll, op.sc, op.addr, stalls, ld_out);
        op_num++;
    endtask

    function automatic op_t rand_op();
        op_t o;
        logic [31:0] bases [4];
        int kind;
        bases[0] = 32'h100; bases[1] = 32'h104; bases[2] = 32'h200; bases[3] = 32'h204;
        kind = int'($urandom_range(0, 5));
        o = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)),
               $urandom, int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 2) == 0),
               bases[$urandom_range(0, 3)], 0, 32'h0);
        case (kind)
            0: begin o.v = 1'b0; o.r = 1'($urandom_range(0, 1)); end
            1: ;
            2: o.r = 1'b1;
            3: o.w = 1'b1;
            4: begin o.r = 1'b1; o.ll = 1'b1; end
            default: begin o.w = 1'b1; o.sc = 1'b1; end
        endcase
        return o;
    endfunction

    op_t         tbl [14];
    int          st;
    logic [31:0] ldv;
    op_t         rop;

    initial begin
        // Expected stall counts / MEM load value per directed op.
        tbl[0]  = mk(1,0,0,0,0, 32'h0000_0040, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        tbl[1]  = mk(0,1,0,0,0, 32'h0000_0044, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        tbl[2]  = mk(1,1,0,0,0, 32'h0000_0104, 32'h0, 2, 32'hDEADBEEF, 0, 32'h0, 4, 32'hDEADBEEF);
        tbl[3]  = mk(1,0,1,0,0, 32'h0000_0108, 32'h11, 0, 32'h0, 0, 32'h0, 2, 32'hDEADBEEF);
        tbl[4]  = mk(1,1,0,1,0, 32'h0000_0200, 32'h0, 1, 32'hCAFE0001, 0, 32'h0, 3, 32'hCAFE0001);
        tbl[5]  = mk(1,0,1,0,1, 32'h0000_0200, 32'h22, 0, 32'h0, 0, 32'h0, 2, 32'h1);
        tbl[6]  = mk(1,0,1,0,1, 32'h0000_0200, 32'h33, 0, 32'h0, 0, 32'h0, LLSC ? 1 : 2, LLSC ? 32'h0 : 32'h1);
        tbl[7]  = mk(1,1,0,1,0, 32'h0000_0200, 32'h0, 0, 32'h55, 0, 32'h0, 2, 32'h55);
        tbl[8]  = mk(1,0,1,0,1, 32'h0000_0200, 32'h44, 0, 32'h0, 1, 32'h200, LLSC ? 1 : 2, LLSC ? 32'h0 : 32'h1);
        tbl[9]  = mk(1,0,1,0,1, 32'h0000_0300, 32'h66, 0, 32'h0, 0, 32'h0, LLSC ? 1 : 2, LLSC ? 32'h0 : 32'h1);
        tbl[10] = mk(1,1,0,1,0, 32'h0000_0204, 32'h0, 0, 32'h7, 0, 32'h0, 2, 32'h7);
        tbl[11] = mk(1,0,1,0,0, 32'h0000_0206, 32'h77, 1, 32'h0, 0, 32'h0, 3, 32'h7);
        tbl[12] = mk(1,0,1,0,1, 32'h0000_0204, 32'h88, 0, 32'h0, 0, 32'h0, LLSC ? 1 : 2, LLSC ? 32'h0 : 32'h1);
        tbl[13] = mk(1,1,0,1,0, 32'h0000_0200, 32'h0, 0, 32'h99, 0, 32'h0, 2, 32'h99);

        nRST = 1'b1;
        valid_EX_MEM = 0; dREN_EX_MEM = 0; dWEN_EX_MEM = 0; ll_EX_MEM = 0; sc_EX_MEM = 0;
        result_EX_MEM = 0; dmemstore_EX_MEM = 0; dhit = 0; dmemload = 0;
        snoop_inv = 0; snoop_addr = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req", {30'd0, dmemREN, dmemWEN}, 32'd0);
        chk("rst_addr", dmemaddr, 32'h0);
        chk("rst_store", dmemstore, 32'h0);
        chk("rst_ld", dmemload_MEM, 32'h0);
        chk("rst_en", {30'd0, enable_EX_MEM, enable_MEM_WB}, 32'd3);
        chk("rst_stall", 32'(stall_MEM), 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i], st, ldv);
            chk("tbl_stalls", 32'(st), 32'(tbl[i].exp_stalls));
            chk("tbl_ld", ldv, tbl[i].exp_ld);
        end

        // Reset while a load is waiting in REQ, after tbl[13] linked 0x200.
        valid_EX_MEM = 1; dREN_EX_MEM = 1; dWEN_EX_MEM = 0; ll_EX_MEM = 0; sc_EX_MEM = 0;
        result_EX_MEM = 32'h104; dhit = 0;
        @(posedge CLK); #1;
        nRST = 1'b1; dhit = 1'b1; dmemload = 32'hFFFF_FFFF; valid_EX_MEM = 0;
        @(negedge CLK);
        chk("rstreq_ren_before", 32'(dmemREN), 32'd1);
        @(posedge CLK); #1;
        nRST = 1'b0; dhit = 1'b0;
        @(negedge CLK);
        chk("rstreq_ren", 32'(dmemREN), 32'd0);
        chk("rstreq_ld", dmemload_MEM, 32'h0);
        chk("rstreq_en", 32'(enable_EX_MEM), 32'd1);
        chk("rstreq_stall", 32'(stall_MEM), 32'd0);
        @(posedge CLK); #1;
        exp_ld_m = 32'h0;
        link_v = 1'b0;
        run_op(mk(1,0,1,0,1, 32'h200, 32'h5, 0, 32'h0, 0, 32'h0, 0, 32'h0), st, ldv);
        chk("rstreq_sc_stalls", 32'(st), LLSC ? 32'd1 : 32'd2);
        chk("rstreq_sc_ld", ldv, LLSC ? 32'h0 : 32'h1);

        for (int i = 0; i < 150; i++) begin
            rop = rand_op();
            run_op(rop, st, ldv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
